seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Sequential unsigned shift-and-add multiplier. It is the multiply counterpart
//  to the team's combinational 4-bit divider: it produces a 2N-bit product
//  from two N-bit operands over N clock cycles. It sits in the arithmetic
//  datapath with valid/ready handshakes on both the operand and result sides.
// PARAMETERS
//  N   4   operand width in bits (N >= 1); product width is 2*N
// PORTS
//  clk           in   1     single clock; all state updates on rising edge
//  rst_n         in   1     asynchronous, active-low reset
//  in_valid      in   1     operands present on multiplicand/multiplier
//  in_ready      out  1     block can accept operands this cycle
//  multiplicand  in   N     unsigned operand A
//  multiplier    in   N     unsigned operand B
//  out_valid     out  1     product is valid and held stable
//  out_ready     in   1     consumer takes the product this cycle
//  product       out  2*N   unsigned A*B
//  busy          out  1     high while in CALC
// BEHAVIOUR
//  - Clock and reset are fixed: one clock (clk); rst_n is asynchronous and active-low.
//  - Reset (rst_n=0, asynchronous): state=IDLE, acc=0, A/B/count=0.
//    Resulting outputs: product=0, out_valid=0, busy=0, in_ready=1.
//  - States:
//    * IDLE: in_ready=1. On in_valid&&in_ready:
//      latch A=zero-extended multiplicand (2N bits), B=multiplier,
//      acc=0, count=0, then go to CALC.
//    * CALC: in_ready=0, busy=1. Each edge:
//      if B[0] then acc=acc+A (2N-bit, no overflow possible);
//      A=A<<1; B=B>>1; count=count+1.
//      After the N-th iteration, go to DONE.
//      Count width is $clog2(N+1).
//    * DONE: out_valid=1, product=acc, held stable until out_ready.
//      If out_ready=1: the result is consumed.
//      Also in_ready=out_ready (combinational).
//      If out_ready && in_valid: accept new operands on the same edge and go
//      to CALC (no bubble). If out_ready && !in_valid: go to IDLE.
//  - Latency: operand accept at edge t. CALC iterations occur on edges
//    t+1..t+N. out_valid is high in the cycle after edge t+N. Latency is
//    always exactly N cycles, including zero operands (no early exit).
//  - product is always driven from acc:
//    * cleared on accept;
//    * undefined-use (changing) during CALC;
//    * stable in DONE;
//    * retains the last result in IDLE.
//  - in_valid while busy: ignored. Operand changes during CALC/DONE do not
//    affect the in-flight result.
//  - out_ready outside DONE: ignored.
//  - Reset mid-operation: an immediate asynchronous abort to IDLE with all
//    registers cleared. No partial result is ever flagged valid.
//  - Arithmetic: unsigned only. Max product (2^N-1)^2 fits in 2N bits.
// TESTING
//  1. Assert rst_n=0 at any time -> in_ready=1, out_valid=0, busy=0,
//     product=0 asynchronously.
//  2. N=4, accept 13x11 -> busy for 4 cycles, then out_valid=1 and
//     product=8'd143. Hold out_ready=0 for 3 cycles -> product stays 143.
//  3. Boundaries: 15x15 -> 8'd225; 0x9 -> 8'd0; 1x1 -> 8'd1.
//     Each has exactly 4 cycles of latency.
//  4. Back-to-back: in DONE with out_ready=1 and in_valid=1 (7x6) ->
//     accepted on the same edge, with no IDLE cycle.
//     product=8'd42 with out_valid 4 cycles later.
//  5. During CALC, toggle in_valid and change the operands -> in_ready=0 and
//     the result is unchanged. Pulse rst_n low in the 2nd CALC cycle ->
//     out_valid never rises. A subsequent 3x5 yields 8'd15.
//  6. Exhaustive sweep of all 256 operand pairs, random out_ready stalls
//     -> every product equals a*b and every result is delivered exactly once.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// N iterations per operation, valid/ready handshakes on operands and product.
module seq_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int            CW        = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_a;
  logic [N-1:0]   r_b;
  logic [CW-1:0]  r_count;
  logic           w_accept;
  logic           w_last;
  logic [2*N-1:0] w_addend;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_count == LAST_ITER);
  assign w_addend = r_b[0] ? r_a : '0;
  assign product  = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // In DONE the consumer's out_ready doubles as in_ready so a new operation
  // can start on the same edge the previous product is taken.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          w_next = in_valid ? CALC : IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Fixed N iterations with no early exit keeps latency data-independent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_acc   <= '0;
      r_a     <= {{N{1'b0}}, multiplicand};
      r_b     <= multiplier;
      r_count <= '0;
    end else if (r_state == CALC) begin
      r_acc   <= r_acc + w_addend;
      r_a     <= r_a << 1;
      r_b     <= r_b >> 1;
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: accepted operands push a*b, a monitor
// pops and compares on every consumed product and checks latency and holding.
module tb_seq_multiplier;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;

  logic manualReady;
  logic randomReady;
  logic randReady;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  int delivered   = 0;
  int issued      = 0;
  int expQ[$];
  int acceptQ[$];
  bit seenValid   = 0;
  logic [2*N-1:0] holdVal;

  assign out_ready = randomReady ? randReady : manualReady;

  seq_multiplier #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    randReady = ($urandom_range(0, 3) != 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL timeout_%s: got no completion, expected one within budget", name);
  endtask

  // Scoreboard monitor: the reference is plain a*b of the operands seen at the
  // handshake; latency is measured from the accept edge.
  always begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      expQ.delete();
      acceptQ.delete();
      seenValid = 0;
    end else begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!seenValid) begin
            checkOutput("latency", cyc - acceptQ[0], N);
            seenValid = 1;
            holdVal   = product;
          end else begin
            checkOutput("hold_stable", {24'd0, product}, {24'd0, holdVal});
          end
          if (out_ready) begin
            checkOutput("product", {24'd0, product}, expQ.pop_front());
            void'(acceptQ.pop_front());
            seenValid = 0;
            delivered++;
          end
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(int'(multiplicand) * int'(multiplier));
        acceptQ.push_back(cyc + 1);
      end
    end
  end

  task automatic syncPos();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
    bit ok = 0;
    in_valid     = 1'b1;
    multiplicand = a;
    multiplier   = b;
    issued++;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) reportTimeout("accept");
    syncPos();
    in_valid     = 1'b0;
    multiplicand = N'($urandom);
    multiplier   = N'($urandom);
  endtask

  task automatic waitDrain();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy && !out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) reportTimeout("drain");
    syncPos();
  endtask

  task automatic waitValid();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) reportTimeout("out_valid");
    syncPos();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_busy"},      {31'd0, busy},      32'd0);
    checkOutput({tag, "_product"},   {24'd0, product},   32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b1;
    in_valid     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    manualReady  = 1'b0;
    randomReady  = 1'b0;
    #1 rst_n = 1'b0;
    #2 checkResetState("reset");
    #9 rst_n = 1'b1;
    syncPos();

    // 13x11 with the consumer stalling three extra cycles.
    applyStimulus(4'd13, 4'd11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("calc_busy", {31'd0, busy}, 32'd1);
      checkOutput("calc_no_valid", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    checkOutput("done_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("done_143", {24'd0, product}, 32'd143);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_143", {24'd0, product}, 32'd143);
    end
    syncPos();
    manualReady = 1'b1;
    waitDrain();

    applyStimulus(4'd15, 4'd15);
    waitDrain();
    applyStimulus(4'd0, 4'd9);
    waitDrain();
    applyStimulus(4'd1, 4'd1);
    waitDrain();

    // Back-to-back: new operands taken on the edge that consumes 5x5.
    manualReady = 1'b0;
    applyStimulus(4'd5, 4'd5);
    waitValid();
    manualReady = 1'b1;
    applyStimulus(4'd7, 4'd6);
    @(negedge clk);
    checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
    checkOutput("b2b_no_valid", {31'd0, out_valid}, 32'd0);
    syncPos();
    waitDrain();

    // Operand noise while computing must not disturb the result.
    applyStimulus(4'd9, 4'd14);
    for (int i = 0; i < 3; i++) begin
      in_valid     = 1'($urandom);
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      @(negedge clk);
      checkOutput("calc_in_ready", {31'd0, in_ready}, 32'd0);
      syncPos();
    end
    in_valid = 1'b0;
    waitDrain();

    // Abort in the second compute cycle; the 15x15 must never be reported.
    applyStimulus(4'd15, 4'd15);
    syncPos();
    #1 rst_n = 1'b0;
    #1 checkResetState("abort");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    syncPos();
    applyStimulus(4'd3, 4'd5);
    waitDrain();

    // Exhaustive sweep with random gaps and random consumer stalls.
    randomReady = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) syncPos();
        end
        applyStimulus(N'(a), N'(b));
      end
    end
    randomReady = 1'b0;
    manualReady = 1'b1;
    waitDrain();

    checkOutput("queue_empty", expQ.size(), 32'd0);
    checkOutput("delivered_once", delivered, issued - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
